// File: rtl/l0_cache_assoc.sv
// N-way set-associative write-through L0 data cache with per-byte valids, round-robin
// replacement and a sequential invalidate sweep. Define L0_CACHE_ASSOC_STATS_EN for hit/miss counters.
module l0_cache_assoc #(
    parameter int          NUM_SETS            = 64,
    parameter int          NUM_WAYS            = 2,
    parameter int          XLEN                = 32,
    parameter int          MEM_BYTE_ADDR_WIDTH = 16,
    parameter logic [31:0] MMIO_ADDR           = 32'h4000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lookup_valid,
    input  logic [31:0]       i_lookup_addr,
    input  logic [1:0]        i_lookup_size,
    output logic              o_hit,
    output logic [XLEN-1:0]   o_hit_data,
    input  logic              i_store_valid,
    input  logic [31:0]       i_store_addr,
    input  logic [XLEN-1:0]   i_store_data,
    input  logic [XLEN/8-1:0] i_store_be,
    input  logic              i_fill_valid,
    input  logic [31:0]       i_fill_addr,
    input  logic [XLEN-1:0]   i_fill_data,
    input  logic              i_inval_req,
    output logic              o_busy
`ifdef L0_CACHE_ASSOC_STATS_EN
    ,
    output logic [31:0]       o_hit_count,
    output logic [31:0]       o_miss_count
`endif
);

    localparam int LANES = XLEN / 8;
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = MEM_BYTE_ADDR_WIDTH - 2 - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    logic [7:0]       data_mem  [NUM_WAYS][LANES][NUM_SETS];
    logic [TAG_W-1:0] tag_mem   [NUM_WAYS][NUM_SETS];
    logic [LANES-1:0] valid_mem [NUM_WAYS][NUM_SETS];
    logic [WAY_W-1:0] rr_mem    [NUM_SETS];

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic             busy;

    function automatic logic cacheable(input logic [31:0] addr);
        return (addr < MMIO_ADDR) && ((addr >> MEM_BYTE_ADDR_WIDTH) == 32'd0);
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] offs);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (i < (1 << size));
        end
        return m << offs;
    endfunction

    // Reset holds the sweep at set 0, so busy must also cover the reset cycles themselves.
    assign busy   = (state == SWEEP) || !i_rst_n;
    assign o_busy = busy;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (i_inval_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                if (i_inval_req) begin
                    cnt_nxt = '0;
                end else if (cnt == IDX_W'(NUM_SETS - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = SWEEP;
                cnt_nxt   = '0;
            end
        endcase
    end

    logic [IDX_W-1:0]    lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [LANES-1:0]    lk_mask;
    logic                lk_cacheable;
    logic [NUM_WAYS-1:0] way_hit;
    logic [XLEN-1:0]     hit_word;

    assign lk_idx       = i_lookup_addr[2 +: IDX_W];
    assign lk_tag       = i_lookup_addr[2 + IDX_W +: TAG_W];
    assign lk_mask      = lane_mask(i_lookup_size, i_lookup_addr[1:0]);
    assign lk_cacheable = cacheable(i_lookup_addr);

    always_comb begin
        way_hit  = '0;
        hit_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_hit[w] = (tag_mem[w][lk_idx] == lk_tag) &&
                         ((valid_mem[w][lk_idx] & lk_mask) == lk_mask);
            for (int l = 0; l < LANES; l++) begin
                if (way_hit[w]) hit_word[l*8 +: 8] |= data_mem[w][l][lk_idx];
            end
        end
    end

    assign o_hit      = i_lookup_valid && lk_cacheable && !busy && $onehot(way_hit);
    assign o_hit_data = o_hit ? hit_word : '0;

    // One shared write port: a cacheable store wins the port over a fill.
    logic             store_go, fill_go, write_go;
    logic [31:0]      w_addr;
    logic [XLEN-1:0]  w_data;
    logic [LANES-1:0] w_be;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_match;
    logic [WAY_W-1:0] w_way;
    logic [LANES-1:0] w_valid;

    assign store_go = !busy && i_store_valid && cacheable(i_store_addr);
    assign fill_go  = !busy && i_fill_valid && cacheable(i_fill_addr) && !store_go;
    assign write_go = store_go || fill_go;
    assign w_addr   = store_go ? i_store_addr : i_fill_addr;
    assign w_data   = store_go ? i_store_data : i_fill_data;
    assign w_be     = store_go ? i_store_be : '1;
    assign w_idx    = w_addr[2 +: IDX_W];
    assign w_tag    = w_addr[2 + IDX_W +: TAG_W];

    always_comb begin
        w_match = 1'b0;
        w_way   = rr_mem[w_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (tag_mem[w][w_idx] == w_tag) begin
                w_match = 1'b1;
                w_way   = WAY_W'(w);
            end
        end
        w_valid = w_match ? (valid_mem[w_way][w_idx] | w_be) : w_be;
    end

    always_ff @(posedge i_clk) begin
        if (state == SWEEP) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_mem[w][cnt] <= '0;
            end
            rr_mem[cnt] <= '0;
        end else if (write_go) begin
            tag_mem[w_way][w_idx]   <= w_tag;
            valid_mem[w_way][w_idx] <= w_valid;
            for (int l = 0; l < LANES; l++) begin
                if (w_be[l]) data_mem[w_way][l][w_idx] <= w_data[l*8 +: 8];
            end
            if (!w_match && (NUM_WAYS > 1)) rr_mem[w_idx] <= rr_mem[w_idx] + 1'b1;
        end
    end

    // Allocation only happens when no way carries the tag, so valid ways never share a tag.
    always @(posedge i_clk) begin
        if (!busy) begin
            for (int a = 0; a < NUM_WAYS; a++) begin
                for (int b = a + 1; b < NUM_WAYS; b++) begin
                    assert (!((|valid_mem[a][lk_idx]) && (|valid_mem[b][lk_idx]) &&
                              (tag_mem[a][lk_idx] == tag_mem[b][lk_idx])));
                end
            end
        end
    end

`ifdef L0_CACHE_ASSOC_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else if (i_lookup_valid && lk_cacheable && !busy) begin
            if (o_hit) o_hit_count  <= o_hit_count + 1'b1;
            else       o_miss_count <= o_miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_l0_cache_assoc.sv
// Directed bench for l0_cache_assoc: table of lookups against a known cache state plus
// hand-written sequences for reset, write-port priority and invalidate restart.
module tb_l0_cache_assoc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic [1:0]  lookup_size = '0;
    logic        hit;
    logic [31:0] hit_data;
    logic        store_valid = 1'b0;
    logic [31:0] store_addr = '0;
    logic [31:0] store_data = '0;
    logic [3:0]  store_be = '0;
    logic        fill_valid = 1'b0;
    logic [31:0] fill_addr = '0;
    logic [31:0] fill_data = '0;
    logic        inval_req = 1'b0;
    logic        busy;
`ifdef L0_CACHE_ASSOC_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l0_cache_assoc dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lookup_valid(lookup_valid), .i_lookup_addr(lookup_addr), .i_lookup_size(lookup_size),
        .o_hit(hit), .o_hit_data(hit_data),
        .i_store_valid(store_valid), .i_store_addr(store_addr), .i_store_data(store_data),
        .i_store_be(store_be),
        .i_fill_valid(fill_valid), .i_fill_addr(fill_addr), .i_fill_data(fill_data),
        .i_inval_req(inval_req), .o_busy(busy)
`ifdef L0_CACHE_ASSOC_STATS_EN
        , .o_hit_count(hit_count), .o_miss_count(miss_count)
`endif
    );

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic look(input string name, input logic [31:0] a, input logic [1:0] sz,
                        input logic eh, input logic [31:0] ed, input logic [31:0] dm);
        lookup_valid = 1'b1;
        lookup_addr  = a;
        lookup_size  = sz;
        #1;
        chk({name, ".hit"}, {31'b0, hit}, {31'b0, eh});
        chk({name, ".data"}, hit_data & dm, ed & dm);
        lookup_valid = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        fill_valid = 1'b1;
        fill_addr  = a;
        fill_data  = d;
        @(negedge clk);
        fill_valid = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        store_valid = 1'b1;
        store_addr  = a;
        store_data  = d;
        store_be    = be;
        @(negedge clk);
        store_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
`ifdef L0_CACHE_ASSOC_STATS_EN
        logic [31:0] h0, m0;
`endif
        // Expected state: set 0 way0 tag 2 = C3C30200, way1 tag 1 = A5A50100
        tbl[0]  = '{1'b1, 32'h0000_0000, 2'd2, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h0000_0100, 2'd2, 1'b1, 32'hA5A5_0100};
        tbl[2]  = '{1'b1, 32'h0000_0200, 2'd2, 1'b1, 32'hC3C3_0200};
        tbl[3]  = '{1'b1, 32'h0000_0101, 2'd0, 1'b1, 32'hA5A5_0100};
        tbl[4]  = '{1'b1, 32'h0000_0202, 2'd1, 1'b1, 32'hC3C3_0200};
        tbl[5]  = '{1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h0000_0300, 2'd2, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 32'h0000_0104, 2'd2, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 32'h4000_0200, 2'd2, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 32'h0001_0100, 2'd2, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 32'h0000_0103, 2'd0, 1'b1, 32'hA5A5_0100};

        // Reset held two cycles
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_addr  = 32'h0000_0100;
        lookup_size  = 2'd2;
        #1;
        chk("rst.busy", {31'b0, busy}, 32'd1);
        chk("rst.hit", {31'b0, hit}, 32'd0);
        chk("rst.data", hit_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.busy", {31'b0, busy}, 32'd1);
        chk("rel.hit", {31'b0, hit}, 32'd0);
        chk("rel.data", hit_data, 32'd0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        lookup_valid = 1'b0;
        chk("rst.busy_len", n, 32'd64);

        // Fill then word/byte lookups
        fill(32'h0000_0100, 32'hDEAD_BEEF);
        look("fill.word", 32'h0000_0100, 2'd2, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        look("fill.byte", 32'h0000_0103, 2'd0, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

        // Store miss allocates with only the written lanes valid
        store(32'h0000_0200, 32'h0000_1234, 4'b0011);
        look("st.word", 32'h0000_0200, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
        look("st.half", 32'h0000_0200, 2'd1, 1'b1, 32'h0000_1234, 32'h0000_FFFF);
        look("st.byte2", 32'h0000_0202, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);

        // Conflict in set 0: third fill evicts the first
        fill(32'h0000_0000, 32'h1111_1111);
        fill(32'h0000_0100, 32'hA5A5_0100);
        fill(32'h0000_0200, 32'hC3C3_0200);
        for (int i = 0; i < 11; i++) begin
            lookup_valid = tbl[i].vld;
            lookup_addr  = tbl[i].addr;
            lookup_size  = tbl[i].size;
            #1;
            chk($sformatf("tbl%0d.hit", i), {31'b0, hit}, {31'b0, tbl[i].hit});
            chk($sformatf("tbl%0d.data", i), hit_data, tbl[i].data);
            lookup_valid = 1'b0;
        end

        // Store and fill to the same line in one cycle: store wins, fill dropped
        store_valid = 1'b1; store_addr = 32'h0000_0300; store_data = 32'hABCD_0000; store_be = 4'b1100;
        fill_valid  = 1'b1; fill_addr  = 32'h0000_0300; fill_data  = 32'h9999_9999;
        @(negedge clk);
        store_valid = 1'b0;
        fill_valid  = 1'b0;
        look("sf.word", 32'h0000_0300, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
        look("sf.hi", 32'h0000_0302, 2'd1, 1'b1, 32'hABCD_0000, 32'hFFFF_0000);
        look("sf.lo", 32'h0000_0300, 2'd1, 1'b0, 32'h0, 32'hFFFF_FFFF);
        look("sf.evict", 32'h0000_0100, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);

        // MMIO fill must not allocate
        fill(32'h4000_0000, 32'h5555_5555);
        look("mmio.look", 32'h4000_0000, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
        look("mmio.keep", 32'h0000_0200, 2'd2, 1'b1, 32'hC3C3_0200, 32'hFFFF_FFFF);
        look("mmio.noalloc", 32'h0000_0000, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);

        // Same-cycle lookup sees pre-write contents
        fill_valid = 1'b1; fill_addr = 32'h0000_0400; fill_data = 32'h0BAD_F00D;
        look("byp.same", 32'h0000_0400, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        fill_valid = 1'b0;
        look("byp.next", 32'h0000_0400, 2'd2, 1'b1, 32'h0BAD_F00D, 32'hFFFF_FFFF);
        look("byp.evict", 32'h0000_0200, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
        store(32'h0000_0400, 32'h0000_00EE, 4'b0001);
        look("merge.word", 32'h0000_0400, 2'd2, 1'b1, 32'h0BAD_F0EE, 32'hFFFF_FFFF);
        look("merge.other", 32'h0000_0302, 2'd1, 1'b1, 32'hABCD_0000, 32'hFFFF_0000);

        // Invalidate, re-pulsed at count 10; a store during the sweep is ignored
        @(negedge clk);
        inval_req = 1'b1;
        @(negedge clk);
        inval_req = 1'b0;
        #1;
        n = 0;
        while (busy && n < 300) begin
            n++;
            lookup_valid = (n == 1);
            lookup_addr  = 32'h0000_0400;
            lookup_size  = 2'd2;
            if (n == 1) begin
                #1;
                chk("inv.hit", {31'b0, hit}, 32'd0);
            end
            inval_req   = (n == 11);
            store_valid = (n == 40);
            store_addr  = 32'h0000_0014;
            store_data  = 32'h7777_7777;
            store_be    = 4'b1111;
            @(negedge clk);
            #1;
        end
        lookup_valid = 1'b0;
        inval_req    = 1'b0;
        store_valid  = 1'b0;
        chk("inv.busy_len", n, 32'd75);
        look("inv.cleared", 32'h0000_0400, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
        look("inv.cleared2", 32'h0000_0302, 2'd1, 1'b0, 32'h0, 32'hFFFF_FFFF);
        look("inv.nostore", 32'h0000_0014, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);

`ifdef L0_CACHE_ASSOC_STATS_EN
        @(negedge clk);
        fill(32'h0000_0600, 32'h6666_6666);
        h0 = hit_count;
        m0 = miss_count;
        lookup_valid = 1'b1;
        lookup_addr = 32'h0000_0600; lookup_size = 2'd2; @(negedge clk);
        lookup_addr = 32'h0000_0601; lookup_size = 2'd0; @(negedge clk);
        lookup_addr = 32'h0000_0700; lookup_size = 2'd2; @(negedge clk);
        lookup_addr = 32'h0000_0602; lookup_size = 2'd1; @(negedge clk);
        lookup_addr = 32'h4000_0000; lookup_size = 2'd2; @(negedge clk);
        lookup_addr = 32'h0000_0014; lookup_size = 2'd2; @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        chk("stats.hit", hit_count - h0, 32'd3);
        chk("stats.miss", miss_count - m0, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
